// File: rtl/pipe_scroller_if.sv
// Signal bundle between the game controller, pipe_scroller and display_module.
// Carries the per-frame control inputs and the three-pipe obstacle field outputs.
interface pipe_scroller_if;
   // frame_tick is a one-clk strobe with no back-pressure; the scroller samples
   // frame_tick, state and level together on the same clk edge.
   logic        frame_tick;
   logic [2:0]  state;
   logic [1:0]  level;
   logic [10:0] pipe_center_0;
   logic [10:0] pipe_center_1;
   logic [10:0] pipe_center_2;
   logic [10:0] pipe_position_0;
   logic [10:0] pipe_position_1;
   logic [10:0] pipe_position_2;
   logic [10:0] pipe_distance_0;
   logic [10:0] pipe_distance_1;
   logic [10:0] pipe_distance_2;
   logic [7:0]  score;
   logic        score_pulse;

   modport master (
      input  frame_tick, state, level,
      output pipe_center_0, pipe_center_1, pipe_center_2,
      output pipe_position_0, pipe_position_1, pipe_position_2,
      output pipe_distance_0, pipe_distance_1, pipe_distance_2,
      output score, score_pulse
   );

   modport slave (
      output frame_tick, state, level,
      input  pipe_center_0, pipe_center_1, pipe_center_2,
      input  pipe_position_0, pipe_position_1, pipe_position_2,
      input  pipe_distance_0, pipe_distance_1, pipe_distance_2,
      input  score, score_pulse
   );
endinterface

// File: rtl/pipe_scroller.sv
// Three-pipe obstacle field: per-frame scroll, LFSR-driven respawn off the right
// edge, level-dependent gap and speed, and a saturating score of pipes cleared.
module pipe_scroller #(
   parameter int         H_ACTIVE     = 640,
   parameter int         PIPE_SPACING = 220,
   parameter int         PIPE_WIDTH   = 52,
   parameter int         BIRD_X       = 200,
   parameter int         CENTER_MIN   = 120,
   parameter int         CENTER_MAX   = 360,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input logic            clk,
   input logic            rst_n,
   pipe_scroller_if.master bus
);

   localparam logic [10:0] RESPAWN_ADV = 11'(3 * PIPE_SPACING);
   localparam logic [10:0] WIDTH_W     = 11'(PIPE_WIDTH);
   localparam logic [10:0] BIRD_W      = 11'(BIRD_X);
   localparam logic [10:0] CMIN_W      = 11'(CENTER_MIN);
   localparam logic [10:0] CMAX_W      = 11'(CENTER_MAX);
   localparam logic [10:0] CENTER_RST  = 11'd240;

   function automatic logic [10:0] gap_of(input logic [1:0] lv);
      case (lv)
         2'd0:    gap_of = 11'd100;
         2'd1:    gap_of = 11'd80;
         2'd2:    gap_of = 11'd65;
         default: gap_of = 11'd50;
      endcase
   endfunction

   logic [10:0] pos_q    [3];
   logic [10:0] center_q [3];
   logic [10:0] dist_q   [3];
   logic [7:0]  score_q;
   logic [7:0]  lfsr_q;
   logic        pulse_q;

   logic [10:0] step;
   logic [10:0] gap;
   logic [10:0] c_raw;
   logic [10:0] c_new;
   logic [7:0]  lfsr_next;
   logic [10:0] new_pos [3];
   logic [2:0]  respawn;
   logic [2:0]  hit;

   always_comb begin
      step      = 11'(bus.level) + 11'd1;
      gap       = gap_of(bus.level);
      c_raw     = CMIN_W + {3'd0, lfsr_q};
      // Values past the top fold back down by 128 so the centre stays in range.
      c_new     = (c_raw > CMAX_W) ? (c_raw - 11'd128) : c_raw;
      lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);
      respawn   = '0;
      hit       = '0;
      for (int i = 0; i < 3; i++) begin
         new_pos[i] = pos_q[i] - step;
         respawn[i] = (pos_q[i] < step);
         if (respawn[i]) begin
            new_pos[i] = pos_q[i] + RESPAWN_ADV - step;
         end
         hit[i] = !respawn[i] && ((pos_q[i] + WIDTH_W) >= BIRD_W) &&
                  ((new_pos[i] + WIDTH_W) < BIRD_W);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            pos_q[i]    <= 11'(H_ACTIVE + i * PIPE_SPACING);
            center_q[i] <= CENTER_RST;
            dist_q[i]   <= gap_of(2'd0);
         end
         score_q <= 8'd0;
         pulse_q <= 1'b0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         pulse_q <= 1'b0;
         if (bus.state == 3'd0) begin
            for (int i = 0; i < 3; i++) begin
               pos_q[i]    <= 11'(H_ACTIVE + i * PIPE_SPACING);
               center_q[i] <= CENTER_RST;
               dist_q[i]   <= gap;
            end
            score_q <= 8'd0;
            lfsr_q  <= LFSR_SEED;
         end else if (bus.state == 3'd1 && bus.frame_tick) begin
            for (int i = 0; i < 3; i++) begin
               pos_q[i] <= new_pos[i];
               if (respawn[i]) begin
                  center_q[i] <= c_new;
                  dist_q[i]   <= gap;
               end
            end
            lfsr_q <= lfsr_next;
            if (|hit) begin
               pulse_q <= 1'b1;
               if (score_q != 8'hFF) begin
                  score_q <= score_q + 8'd1;
               end
            end
         end
      end
   end

   assign bus.pipe_position_0 = pos_q[0];
   assign bus.pipe_position_1 = pos_q[1];
   assign bus.pipe_position_2 = pos_q[2];
   assign bus.pipe_center_0   = center_q[0];
   assign bus.pipe_center_1   = center_q[1];
   assign bus.pipe_center_2   = center_q[2];
   assign bus.pipe_distance_0 = dist_q[0];
   assign bus.pipe_distance_1 = dist_q[1];
   assign bus.pipe_distance_2 = dist_q[2];
   assign bus.score           = score_q;
   assign bus.score_pulse     = pulse_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: reset/READY values, scrolling, scoring,
// respawn with reference LFSR centre, level change, saturation, freeze and async reset.
module tb_pipe_scroller;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   pulse_cnt;
   logic found;
   logic [31:0] exp_q[$];

   pipe_scroller_if bus ();

   pipe_scroller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_pos(input string tag, input int e0, input int e1, input int e2);
      exp_q.push_back(32'(e0));
      exp_q.push_back(32'(e1));
      exp_q.push_back(32'(e2));
      check({tag, "_pos0"}, 32'(bus.pipe_position_0), exp_q.pop_front());
      check({tag, "_pos1"}, 32'(bus.pipe_position_1), exp_q.pop_front());
      check({tag, "_pos2"}, 32'(bus.pipe_position_2), exp_q.pop_front());
   endtask

   // One frame_tick pulse; returns on the negedge after the capturing posedge.
   task automatic do_tick();
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      if (bus.score_pulse === 1'b1) pulse_cnt++;
   endtask

   task automatic do_ticks(input int n);
      for (int k = 0; k < n; k++) do_tick();
   endtask

   function automatic logic [7:0] lfsr_after(input int n);
      logic [7:0] l;
      l = 8'hA5;
      for (int k = 0; k < n; k++) begin
         if (l[0]) l = (l >> 1) ^ 8'hB8;
         else      l = l >> 1;
      end
      return l;
   endfunction

   function automatic int center_of(input logic [7:0] l);
      int c;
      c = 120 + int'(l);
      if (c > 360) c = c - 128;
      return c;
   endfunction

   initial begin
      int c_exp;
      n_checks = 0;
      n_pass = 0;
      pulse_cnt = 0;
      rst_n = 1'b0;
      bus.frame_tick = 1'b0;
      bus.state = 3'd0;
      bus.level = 2'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check_pos("reset", 640, 860, 1080);
      check("reset_c0", 32'(bus.pipe_center_0), 240);
      check("reset_c1", 32'(bus.pipe_center_1), 240);
      check("reset_c2", 32'(bus.pipe_center_2), 240);
      check("reset_d0", 32'(bus.pipe_distance_0), 100);
      check("reset_d1", 32'(bus.pipe_distance_1), 100);
      check("reset_d2", 32'(bus.pipe_distance_2), 100);
      check("reset_score", 32'(bus.score), 0);
      check("reset_pulse", 32'(bus.score_pulse), 0);

      // Level 0 scroll
      bus.state = 3'd1;
      do_ticks(10);
      check_pos("t10", 630, 850, 1070);
      check("t10_pulses", 32'(pulse_cnt), 0);
      repeat (3) @(negedge clk);
      check_pos("hold", 630, 850, 1070);

      // First score on tick 493
      do_ticks(482);
      check("t492_score", 32'(bus.score), 0);
      check("t492_pos0", 32'(bus.pipe_position_0), 148);
      do_tick();
      check("t493_pos0", 32'(bus.pipe_position_0), 147);
      check("t493_pulse", 32'(bus.score_pulse), 1);
      check("t493_score", 32'(bus.score), 1);
      @(negedge clk);
      check("t493_pulse_clr", 32'(bus.score_pulse), 0);

      // Pipe 0 reaches 0 then respawns
      do_ticks(147);
      check_pos("t640", 0, 220, 440);
      do_tick();
      c_exp = center_of(lfsr_after(640));
      check("t641_pos0", 32'(bus.pipe_position_0), 659);
      check("t641_d0", 32'(bus.pipe_distance_0), 100);
      check("t641_c0", 32'(bus.pipe_center_0), 32'(c_exp));
      check("t641_c0_range", 32'(bus.pipe_center_0 >= 11'd120 && bus.pipe_center_0 <= 11'd360), 1);
      check("t641_score", 32'(bus.score), 1);

      // Tick on the same clk as PLAY->OVER, then 20 ignored ticks
      @(negedge clk);
      bus.state = 3'd2;
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      check_pos("over_edge", 659, 219, 439);
      do_ticks(20);
      check_pos("over20", 659, 219, 439);
      check("over20_c0", 32'(bus.pipe_center_0), 32'(c_exp));
      check("over20_score", 32'(bus.score), 1);

      // READY at level 3 within one clk
      bus.state = 3'd0;
      bus.level = 2'd3;
      @(negedge clk);
      check_pos("ready", 640, 860, 1080);
      check("ready_c0", 32'(bus.pipe_center_0), 240);
      check("ready_d0", 32'(bus.pipe_distance_0), 50);
      check("ready_d2", 32'(bus.pipe_distance_2), 50);
      check("ready_score", 32'(bus.score), 0);

      // 100 ticks at level 0 then level 3
      bus.level = 2'd0;
      @(negedge clk);
      bus.state = 3'd1;
      do_ticks(100);
      check_pos("l0_100", 540, 760, 980);
      bus.level = 2'd3;
      do_ticks(5);
      check_pos("l3_5", 520, 740, 960);
      check("l3_5_d0", 32'(bus.pipe_distance_0), 100);
      do_ticks(131);
      check_pos("l3_resp", 656, 216, 436);
      check("l3_resp_d0", 32'(bus.pipe_distance_0), 50);
      check("l3_resp_d1", 32'(bus.pipe_distance_1), 100);
      check("l3_resp_c0", 32'(bus.pipe_center_0), 32'(center_of(lfsr_after(235))));
      check("l3_resp_score", 32'(bus.score), 1);

      // Continuous ticks to saturate the score, then one more crossing
      @(negedge clk);
      bus.frame_tick = 1'b1;
      repeat (15000) @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
      check("sat_score", 32'(bus.score), 255);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         do_tick();
         if (bus.score_pulse === 1'b1) found = 1'b1;
      end
      check("sat_found", 32'(found), 1);
      check("sat_pulse", 32'(bus.score_pulse), 1);
      check("sat_score_hold", 32'(bus.score), 255);

      // Async reset mid-cycle
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_pos("arst", 640, 860, 1080);
      check("arst_d0", 32'(bus.pipe_distance_0), 100);
      check("arst_score", 32'(bus.score), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
